// File: rtl/disp_scan_pkg.sv
// Shared types and helpers for the four-digit seven-segment scan controller.
package disp_scan_pkg;

    // Each digit slot starts blanked (DEAD) and then lights the digit (SHOW).
    typedef enum logic {
        DEAD = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    // Anode pattern with every digit switched off (anodes are active-low).
    localparam logic [3:0] AN_OFF = 4'b1111;

    // Width of the digit index; four digits need two bits.
    localparam int IDX_W = 2;

    // Returns the one-hot-low anode code that selects digit idx.
    function automatic logic [3:0] an_sel(input logic [IDX_W-1:0] idx);
        an_sel = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/disp_scan_timer.sv
// Slot timer: counts clock cycles within one digit slot and flags the
// blanked start of the slot, its last blanked cycle and the slot's final cycle.
module disp_scan_timer #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic dead_o,
    output logic dead_last_o,
    output logic slot_end_o
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count wraps to zero on the last cycle of the slot.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (slot_end_o) begin
            cnt_d = '0;
        end
    end

    // Slot counter register; reset puts us at the very start of a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dead_o      = (cnt_q < DEAD_CNT);
    assign dead_last_o = (cnt_q == DEAD_END);
    assign slot_end_o  = (cnt_q == LAST_CNT);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit time-multiplexed scan controller feeding a single hex decoder.
// Loads are staged and only copied into the displayed (shadow) copy at the
// end of digit 3's slot, so one frame never mixes old and new values.
module disp_scan_ctrl
    import disp_scan_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 1000,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  blank_in,
    output logic [3:0]  an_n,
    output logic [3:0]  digit,
    output logic        point_out,
    output logic        le_out,
    output logic        frame_done
);

    logic dead;
    logic dead_last;
    logic slot_end;
    logic commit;

    logic [15:0]      stg_hex_q;
    logic [3:0]       stg_pt_q;
    logic [3:0]       stg_bl_q;
    logic             pending_q;
    logic [15:0]      shd_hex_q;
    logic [3:0]       shd_pt_q;
    logic [3:0]       shd_bl_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       digit_q;
    logic             frame_done_q;
    logic [3:0]       lz_blank;

    scan_state_e state_q;
    scan_state_e state_d;

    disp_scan_timer #(
        .DIGIT_CYCLES(DIGIT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .dead_o     (dead),
        .dead_last_o(dead_last),
        .slot_end_o (slot_end)
    );

    // The frame boundary is the last cycle of digit 3's slot.
    assign commit = slot_end && (idx_q == IDX_W'(3));

    // Staging and shadow registers; a load on the commit cycle bypasses staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_hex_q <= '0;
            stg_pt_q  <= '0;
            stg_bl_q  <= '0;
            pending_q <= 1'b0;
            shd_hex_q <= '0;
            shd_pt_q  <= '0;
            shd_bl_q  <= '0;
        end else begin
            if (load) begin
                stg_hex_q <= hex_in;
                stg_pt_q  <= point_in;
                stg_bl_q  <= blank_in;
            end
            if (commit) begin
                pending_q <= 1'b0;
                if (load) begin
                    shd_hex_q <= hex_in;
                    shd_pt_q  <= point_in;
                    shd_bl_q  <= blank_in;
                end else if (pending_q) begin
                    shd_hex_q <= stg_hex_q;
                    shd_pt_q  <= stg_pt_q;
                    shd_bl_q  <= stg_bl_q;
                end
            end else if (load) begin
                pending_q <= 1'b1;
            end
        end
    end

    // Digit index, held digit value and frame pulse, all advanced by the slot timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            digit_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            if (slot_end) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            digit_q      <= digit;
            frame_done_q <= commit;
        end
    end

    // Leading-zero mask: a digit blanks when it and every digit to its left are
    // zero, unless it carries a point; the rightmost digit always shows.
    always_comb begin
        lz_blank = '0;
        for (int i = 1; i < 4; i++) begin
            lz_blank[i] = (LZ_SUPPRESS != 0)
                        && ((shd_hex_q >> (4 * i)) == 16'h0000)
                        && !shd_pt_q[i];
        end
    end

    // State register for the per-slot DEAD/SHOW sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and decoder-facing outputs; anodes only turn on once both the
    // FSM and the timer agree the dead time is over.
    always_comb begin
        state_d   = state_q;
        an_n      = AN_OFF;
        digit     = digit_q;
        point_out = 1'b0;
        le_out    = 1'b1;
        if (slot_end) begin
            state_d = DEAD;
        end else if (dead_last) begin
            state_d = SHOW;
        end
        if ((state_q == SHOW) && !dead) begin
            an_n      = an_sel(idx_q);
            digit     = shd_hex_q[{idx_q, 2'b00} +: 4];
            point_out = shd_pt_q[idx_q];
            le_out    = shd_bl_q[idx_q] | lz_blank[idx_q];
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed 4-digit seven-segment scan controller sitting directly upstream of the single-digit MC14495-style hex decoder. Latches a 16-bit hex value plus per-digit point and blank flags and cycles through the digits. For each digit it drives the decoder's nibble, point and LE inputs and the active-low anode select, with a dead-time gap between digits to suppress ghosting. New values are committed only at frame boundaries, so a displayed frame never tears.

## Interface
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- DEAD_CYCLES, 1000: blanked cycles at the start of each slot; legal range 1 ≤ DEAD_CYCLES < DIGIT_CYCLES.
- LZ_SUPPRESS, 0: when 1, leading zero digits are blanked.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe that captures hex_in, point_in and blank_in.
- hex_in  in  16  four nibbles; [3:0] is digit 0, the rightmost digit.
- point_in  in  4  decimal point request per digit; 1 lights the point.
- blank_in  in  4  per-digit forced blank; 1 blanks the digit.
- an_n  out  4  anode select, active-low, one-hot-low while showing.
- digit  out  4  nibble to the decoder's D3..D0 inputs.
- point_out  out  1  to the decoder's point input.
- le_out  out  1  to the decoder's LE input; 1 blanks the digit.
- frame_done  out  1  one-cycle pulse at the end of digit 3's slot.

## Operation
- Registers:
  - staging: hex, point, blank, pending.
  - shadow: hex, point, blank.
  - 2-bit digit index idx.
  - slot counter cnt, width $clog2(DIGIT_CYCLES).
  - FSM state, one of DEAD or SHOW.
- On load: the inputs go into staging and pending is set to 1. A later load before commit overwrites staging, so the last load wins.
- Commit happens on the cycle where idx==3 and cnt==DIGIT_CYCLES-1. If pending is set, shadow takes staging and pending clears.
  - If load coincides with the commit cycle, shadow takes the live inputs directly and pending stays 0.
- FSM per slot:
  - DEAD for cnt 0..DEAD_CYCLES-1: an_n=4'b1111, le_out=1, point_out=0, and digit holds its last value.
  - SHOW for cnt DEAD_CYCLES..DIGIT_CYCLES-1:
    - an_n[idx]=0 and all other anode bits are 1.
    - digit = shadow nibble idx.
    - point_out = shadow point[idx].
    - le_out = shadow blank[idx], or the leading-zero blank.
- At cnt==DIGIT_CYCLES-1: cnt returns to 0, idx advances by 1 (wrapping 3→0), and the FSM returns to DEAD.
- Leading-zero blank, only when LZ_SUPPRESS=1: digit i≥1 is blanked when shadow nibbles i..3 are all zero. Digit 0 is never suppressed. A digit whose point flag is set is not suppressed.
- While blanked in SHOW (le_out=1), an_n[idx] is still driven low. The decoder blanks the segments itself.
- Every output is driven from flops or from registered state only. There is no combinational path from inputs to outputs.

## Timing
- Reset values, applied asynchronously:
  - an_n=4'b1111, digit=0, point_out=0, le_out=1, frame_done=0.
  - idx=0, cnt=0, state DEAD.
  - shadow and staging all 0, pending=0.
- After rst_n deasserts, the first SHOW of digit 0 starts at cycle DEAD_CYCLES.
- A full frame is 4·DIGIT_CYCLES cycles.
- frame_done is high exactly during the cycle after commit, which is the first DEAD cycle of digit 0.
- Load-to-display latency:
  - Minimum: DEAD_CYCLES+1 cycles, when load lands on the commit cycle.
  - Maximum: 4·DIGIT_CYCLES+DEAD_CYCLES.
- If rst_n is asserted mid-slot, the block returns to its reset values immediately and pending loads are discarded.

## Structure
- Package disp_scan_pkg holds:
  - the state enum {DEAD, SHOW};
  - localparam AN_OFF=4'b1111;
  - the IDX_W=2 constant;
  - the function an_sel(idx), which returns the one-hot-low anode code.
- One sub-module, disp_scan_timer. It holds cnt and reports dead (cnt<DEAD_CYCLES) and slot_end (cnt==DIGIT_CYCLES-1). The top level holds idx, the FSM and the registers.

## Test plan
All scenarios use DIGIT_CYCLES=8 and DEAD_CYCLES=2.
- Reset, then hold: an_n=1111 and le_out=1 during cycles 0–1. From cycle 2, an_n=1110 and digit=0 (shadow is 0).
- Load hex_in=16'h12AF with point_in=4'b0100 at cycle 3 → display is unchanged until the commit at cycle 31. Then frame_done=1 at cycle 32. In the following frame, digits show F, A, 2, 1 on an_n 1110, 1101, 1011, 0111, and point_out=1 only in digit 2's SHOW.
- Two loads, 16'h1111 then 16'h2222, before the same commit → only 2222 is ever displayed.
- Load 16'h3456 exactly on the commit cycle → 16'h3456 is shown starting the next frame, and pending=0.
- LZ_SUPPRESS=1, load 16'h0070 → digits 3 and 2 have le_out=1 during SHOW, while digits 1 and 0 show 7 and 0.
  - With point_in=4'b1000 as well, digit 3 is no longer blanked.
- Assert rst_n=0 during digit 2's SHOW → an_n=1111 and le_out=1 that same cycle. After release, the scan restarts at digit 0 showing 0.
